// File: rtl/ins_seq_pkg.sv
// ins_seq_pkg: opcodes, one-hot op bit positions and FSM states for the sequenced decoder
package ins_seq_pkg;
  localparam logic [3:0] OPC_MOV   = 4'b1100;
  localparam logic [3:0] OPC_ADD   = 4'b1001;
  localparam logic [3:0] OPC_SUB   = 4'b0110;
  localparam logic [3:0] OPC_AND   = 4'b1011;
  localparam logic [3:0] OPC_NOT   = 4'b0101;
  localparam logic [3:0] OPC_SHIFT = 4'b1010;
  localparam logic [3:0] OPC_JUMP  = 4'b0011;
  localparam logic [3:0] OPC_IN    = 4'b0010;
  localparam logic [3:0] OPC_OUT   = 4'b0100;
  localparam logic [3:0] OPC_NOP   = 4'b0111;
  localparam logic [3:0] OPC_HALT  = 4'b1000;
  localparam int OP_MOVA = 0;
  localparam int OP_MOVB = 1;
  localparam int OP_MOVC = 2;
  localparam int OP_ADD  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_AND  = 5;
  localparam int OP_NOT  = 6;
  localparam int OP_RSR  = 7;
  localparam int OP_RSL  = 8;
  localparam int OP_JMP  = 9;
  localparam int OP_JZ   = 10;
  localparam int OP_JC   = 11;
  localparam int OP_IN   = 12;
  localparam int OP_OUT  = 13;
  localparam int OP_NOP  = 14;
  localparam int OP_HALT = 15;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT_IO, S_HALT} state_e;
endpackage

// File: rtl/ins_opcode_dec.sv
// ins_opcode_dec: combinational instruction word to one-hot op plus class flags
module ins_opcode_dec
  import ins_seq_pkg::*;
#(
  parameter int IR_W = 8
) (
  input  logic [IR_W-1:0] ir,
  output logic [15:0]     op,
  output logic            illegal,
  output logic            is_jump,
  output logic            is_io,
  output logic            is_halt
);
  logic [3:0] opc;
  logic [3:0] m;
  assign opc = ir[IR_W-1 -: 4];
  assign m   = ir[3:0];
  // map opcode and mode bits to exactly the op bits they select; unknown opcodes leave op clear
  always_comb begin
    op      = '0;
    illegal = 1'b0;
    case (opc)
      OPC_MOV: begin
        op[OP_MOVB] = m[3] & m[2];
        op[OP_MOVC] = ~(m[3] & m[2]) & m[1] & m[0];
        op[OP_MOVA] = ~(m[3] & m[2]) & ~(m[1] & m[0]);
      end
      OPC_ADD:   op[OP_ADD] = 1'b1;
      OPC_SUB:   op[OP_SUB] = 1'b1;
      OPC_AND:   op[OP_AND] = 1'b1;
      OPC_NOT:   op[OP_NOT] = 1'b1;
      OPC_SHIFT: begin
        op[OP_RSR] = m[1:0] == 2'b00;
        op[OP_RSL] = m[1:0] != 2'b00;
      end
      OPC_JUMP: begin
        op[OP_JC]  = m[1];
        op[OP_JZ]  = m[0];
        op[OP_JMP] = m[1:0] == 2'b00;
      end
      OPC_IN:   op[OP_IN]   = 1'b1;
      OPC_OUT:  op[OP_OUT]  = 1'b1;
      OPC_NOP:  op[OP_NOP]  = 1'b1;
      OPC_HALT: op[OP_HALT] = 1'b1;
      default:  illegal     = 1'b1;
    endcase
  end
  assign is_jump = opc == OPC_JUMP;
  assign is_io   = (opc == OPC_IN) || (opc == OPC_OUT);
  assign is_halt = opc == OPC_HALT;
endmodule

// File: rtl/ins_seq_decoder.sv
// ins_seq_decoder: registered instruction decoder with PC control, I/O wait/timeout and halt FSM
module ins_seq_decoder
  import ins_seq_pkg::*;
#(
  parameter int IR_W  = 8,
  parameter int IO_TO = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [IR_W-1:0] ir_in,
  input  logic            ir_valid,
  output logic            ir_ready,
  input  logic            zf,
  input  logic            cf,
  input  logic            io_ack,
  input  logic            resume,
  output logic [15:0]     op,
  output logic            op_valid,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            halted,
  output logic            illegal,
  output logic            io_timeout
);
  localparam int CW = $clog2(IO_TO);
  state_e          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            zf_q, zf_d, cf_q, cf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     dec_op;
  logic            dec_ill, is_jump, is_io, is_halt, taken, to_hit, busy;
  ins_opcode_dec #(.IR_W(IR_W)) u_dec (
    .ir      (ir_q),
    .op      (dec_op),
    .illegal (dec_ill),
    .is_jump (is_jump),
    .is_io   (is_io),
    .is_halt (is_halt)
  );
  assign taken  = dec_op[OP_JMP] | (dec_op[OP_JZ] & zf_q) | (dec_op[OP_JC] & cf_q);
  assign to_hit = cnt_q == CW'(IO_TO - 1);
  assign busy   = (state_q == S_EXEC) || (state_q == S_WAIT_IO);
  // state, instruction, flag and timeout registers; en=0 freezes all of them
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      ir_q    <= ir_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: capture word and flags on accept, route EXEC by instruction class, count I/O wait
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: if (ir_valid) begin
        ir_d    = ir_in;
        zf_d    = zf;
        cf_d    = cf;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d   = '0;
        state_d = is_io ? S_WAIT_IO : is_halt ? S_HALT : S_FETCH;
      end
      S_WAIT_IO: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (io_ack || to_hit) ? S_FETCH : S_WAIT_IO;
      end
      S_HALT:  state_d = resume ? S_FETCH : S_HALT;
      default: state_d = S_FETCH;
    endcase
  end
  // outputs decoded from registered state and instruction; strobes and pulses gated by en
  always_comb begin
    ir_ready   = en && state_q == S_FETCH;
    op         = busy ? dec_op : '0;
    op_valid   = en && ((state_q == S_EXEC && !dec_ill) || state_q == S_WAIT_IO);
    pc_load    = en && state_q == S_EXEC && is_jump && taken;
    pc_inc     = en && ((state_q == S_EXEC && (is_jump ? !taken : !(is_io || is_halt)))
                        || (state_q == S_WAIT_IO && (io_ack || to_hit)));
    halted     = state_q == S_HALT;
    illegal    = en && state_q == S_EXEC && dec_ill;
    io_timeout = en && state_q == S_WAIT_IO && !io_ack && to_hit;
  end
endmodule

// File: doc/ins_seq_decoder.md
# ins_seq_decoder

Parametrised, sequenced instruction decoder and control FSM for the MyCPU core. It accepts an instruction word from the fetch stage over a valid/ready handshake, registers it, and emits a one-hot operation vector with a validity strobe. It also drives PC control (increment or load on a taken jump), waits on an I/O acknowledge with a timeout for IN/OUT, and holds a sticky halt state. It sits between the fetch/IR register and the datapath/ALU control, and replaces the purely combinational decoder.

## Interface
Parameters:
- IR_W, 8: instruction width, ≥ 8; opcode = ir[IR_W-1:IR_W-4], mode bits = ir[3:0]
- IO_TO, 16: WAIT_IO timeout in cycles, ≥ 2; counter width = $clog2(IO_TO)

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  global enable; 0 freezes state, counter and registers
- ir_in  in  IR_W  instruction word
- ir_valid  in  1  fetch offers ir_in
- ir_ready  out  1  decoder accepts; high only in FETCH with en=1
- zf, cf  in  1 each  ALU zero/carry flags
- io_ack  in  1  I/O device completed IN/OUT
- resume  in  1  leave HALT
- op  out  16  one-hot: 0 mova, 1 movb, 2 movc, 3 add, 4 sub, 5 and, 6 not, 7 rsr, 8 rsl, 9 jmp, 10 jz, 11 jc, 12 in, 13 out, 14 nop, 15 halt
- op_valid  out  1  op is valid this cycle
- pc_inc  out  1  advance PC (1-cycle pulse)
- pc_load  out  1  load jump target (1-cycle pulse)
- halted  out  1  FSM in HALT
- illegal  out  1  undefined opcode (1-cycle pulse)
- io_timeout  out  1  IN/OUT timed out (1-cycle pulse)

## Operation
- Opcode map:
  - 1100 MOV: movb if ir[3]&ir[2]; else movc if ir[1]&ir[0]; else mova.
  - 1001 add, 0110 sub, 1011 and, 0101 not.
  - 1010 shift: rsr if ir[1:0]=00, else rsl.
  - 0011 jump: jc=ir[1], jz=ir[0], jmp if ir[1:0]=00.
  - 0010 in, 0100 out, 0111 nop, 1000 halt.
  - All other opcodes are illegal.
- States: FETCH, EXEC, WAIT_IO, HALT. Reset → FETCH.
- FETCH: ir_ready=1. On ir_valid&ir_ready, register ir_in, zf and cf, then → EXEC.
- EXEC: op=decode(registered ir).
  - Illegal: op=0, op_valid=0, illegal=1, pc_inc=1 → FETCH.
  - Jump: taken = jmp | (jz&zf_reg) | (jc&cf_reg). Taken: pc_load=1, pc_inc=0. Not taken: pc_inc=1. → FETCH.
  - in/out: op_valid=1, no PC pulse, clear counter → WAIT_IO.
  - halt: op_valid=1 → HALT.
  - Otherwise: op_valid=1, pc_inc=1 → FETCH.
- WAIT_IO: op and op_valid held. Counter increments each cycle.
  - io_ack=1: pc_inc=1 → FETCH.
  - Else, counter = IO_TO-1: io_timeout=1, pc_inc=1 → FETCH.
  - io_ack wins over a simultaneous timeout.
- HALT: halted=1, ir_ready=0, op=0. resume=1 → FETCH next cycle. pc_inc is never asserted for halt.
- en=0: state, counter and registers hold. ir_ready, op_valid, pc_inc, pc_load, illegal and io_timeout are forced 0. op holds its value.
- Reset values: state FETCH, op=0, op_valid=0, pc_inc=0, pc_load=0, halted=0, illegal=0, io_timeout=0, counter=0, ir_reg=0. ir_ready=1 from the first cycle after reset.

## Timing
- Accept at edge N; EXEC outputs are valid in cycle N+1; ir_ready returns in N+2. Peak throughput is one instruction per 2 cycles.
- op, op_valid and all pulses are registered outputs, or decoded from registered state only. No combinational path from ir_in to op.
- Flags are sampled at the accept edge, not in EXEC.
- Reset asserted in any state (including WAIT_IO or HALT) applies reset values at the next edge. A pending IN/OUT is abandoned with no pc_inc.

## Structure
- Package ins_seq_pkg holds:
  - opcode localparams (OPC_MOV=4'b1100 … OPC_HALT=4'b1000)
  - op bit indices (OP_MOVA=0 … OP_HALT=15)
  - state enum.
- Sub-module ins_opcode_dec (combinational: ir[IR_W-1:0] → op[15:0], illegal, is_jump, is_io, is_halt) is instantiated once on the registered ir. The FSM and counter live in the top module.

## Test plan
- Reset, then ir_in=8'h90 (add) accepted at edge N → cycle N+1: op=16'h0008, op_valid=1, pc_inc=1; ir_ready=1 at N+2.
- 8'h33 with zf=0, cf=1 at accept → op bits 10 and 11 set, pc_load=1, pc_inc=0. Repeat with zf=cf=0 → pc_inc=1, pc_load=0.
- 8'h20 (in), io_ack on 3rd WAIT_IO cycle → op_valid held 4 cycles total, pc_inc=1 on the ack cycle. No ack with IO_TO=4 → io_timeout and pc_inc in the 4th WAIT_IO cycle.
- 8'h80 (halt) → halted=1, ir_ready=0 while ir_valid=1. resume → FETCH next cycle, halted=0.
- 8'h00 (illegal) → illegal=1, op=0, op_valid=0, pc_inc=1.
- en=0 for 3 cycles mid-WAIT_IO → counter frozen, no pulses. rst asserted in WAIT_IO → all outputs at reset values next cycle.
